reg_file_param: RTL

- Parametrised successor to the processor's 32x32 register file: configurable data width, depth and read-port count, with an optional hardwired-zero register 0.
- Adds same-cycle write-to-read bypass and optional registered reads.
- Adds a hardware clear sequencer, so the register contents are defined after reset without simulation-only initialisation.
- Sits between decode (read addresses) and writeback (write port) in the datapath.

---
 rtl/reg_file_param.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/reg_file_param.sv
// reg_file_param
//   Parameterised register file for the datapath: decode drives the read
//   addresses, writeback drives the single write port. After reset a clear
//   sequencer walks every register and writes zero to it, so no
//   simulation-only initialisation is needed. `ready` rises when that sweep
//   is done.
//
// Ports
//   clk, rst_n    clock; synchronous active-low reset
//   readAddress   NUM_READ packed read addresses (port k at [k*ADDR_WIDTH +: ADDR_WIDTH])
//   readData      NUM_READ packed read data      (port k at [k*DATA_WIDTH +: DATA_WIDTH])
//   writeAddress  write address
//   writeData     write data
//   writeEnable   write strobe, sampled on the rising edge
//   ready         1 once the clear sweep has completed
//   writeDropped  one-cycle pulse: a write arrived while the sweep was running
module reg_file_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    parameter int READ_REG   = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] readAddress,
    output logic [NUM_READ*DATA_WIDTH-1:0] readData,
    input  logic [ADDR_WIDTH-1:0]          writeAddress,
    input  logic [DATA_WIDTH-1:0]          writeData,
    input  logic                           writeEnable,
    output logic                           ready,
    output logic                           writeDropped
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e                          state_q, state_d;
    logic [ADDR_WIDTH:0]             clr_idx_q, clr_idx_d;
    logic                            ready_q, ready_d;
    logic                            write_dropped_q, write_dropped_d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] rf_q, rf_d;
    logic [NUM_READ-1:0][DATA_WIDTH-1:0] rd_val;

    // Next-state: sweep in CLEAR, architectural writes in RUN.
    always_comb begin
        state_d         = state_q;
        clr_idx_d       = clr_idx_q;
        ready_d         = ready_q;
        write_dropped_d = 1'b0;
        rf_d            = rf_q;
        unique case (state_q)
            ST_CLEAR: begin
                rf_d[clr_idx_q[ADDR_WIDTH-1:0]] = '0;
                clr_idx_d       = clr_idx_q + 1'b1;
                // Writes cannot land mid-sweep; flag them so writeback can notice.
                write_dropped_d = writeEnable;
                if (clr_idx_q == CLR_LAST) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (writeEnable && !((ZERO_REG != 0) && (writeAddress == '0)))
                    rf_d[writeAddress] = writeData;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_CLEAR;
            clr_idx_q       <= '0;
            ready_q         <= 1'b0;
            write_dropped_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            clr_idx_q       <= clr_idx_d;
            ready_q         <= ready_d;
            write_dropped_q <= write_dropped_d;
        end
    end

    // Storage is not reset: the sweep defines it. Holding it during reset
    // makes a write coincident with reset vanish.
    always_ff @(posedge clk) begin
        if (rst_n)
            rf_q <= rf_d;
    end

    // Per-port read value; ports are fully independent.
    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] val;

        assign addr = readAddress[k*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            val = '0;
            if ((ZERO_REG != 0) && (addr == '0))
                val = '0;
            else if (state_q == ST_CLEAR)
                val = '0;
            else if ((BYPASS != 0) && writeEnable && (writeAddress == addr))
                val = writeData;
            else
                val = rf_q[addr];
        end

        assign rd_val[k] = val;
    end

    if (READ_REG != 0) begin : g_rd_reg
        logic [NUM_READ*DATA_WIDTH-1:0] rd_q, rd_d;

        assign rd_d = rd_val;

        always_ff @(posedge clk) begin
            if (!rst_n)
                rd_q <= '0;
            else
                rd_q <= rd_d;
        end

        assign readData = rd_q;
    end else begin : g_rd_comb
        assign readData = rd_val;
    end

    assign ready        = ready_q;
    assign writeDropped = write_dropped_q;

endmodule
